core_mem_xbar: RTL and testbench

Parametrised N-master x M-bank crossbar between core req/gnt/rvalid ports (instruction fetch, LSU, DMA) and single-port SRAM banks. It is the next generation of the fixed 2x2 core-to-memory path. AXI conversion, slices and protocol adapters are replaced by direct address decode, per-bank round-robin arbitration and single-cycle response routing. It sits between the core/peripheral masters and the SRAM macros in the SoC top.

---
 rtl/core_mem_xbar_pkg.sv | 24 ++
 rtl/core_mem_xbar_rr_arb.sv | 46 ++++
 rtl/core_mem_xbar.sv | 161 ++++++++++++++++
 tb/tb_core_mem_xbar.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_xbar_pkg.sv
// Shared types and constants for the N-master x M-bank core-to-SRAM crossbar.
// Index widths are sized for the largest supported configuration (8 masters, 8 banks).
package core_mem_xbar_pkg;

    localparam int unsigned MAX_MASTER   = 8;
    localparam int unsigned MAX_BANK     = 8;
    localparam int unsigned BANK_IDX_W   = (MAX_BANK > 1) ? $clog2(MAX_BANK) : 1;
    localparam int unsigned MASTER_IDX_W = (MAX_MASTER > 1) ? $clog2(MAX_MASTER) : 1;

    typedef logic [BANK_IDX_W-1:0]   bank_idx_t;
    typedef logic [MASTER_IDX_W-1:0] master_idx_t;

    // One outstanding response per master: which bank to route, or a miss/write with no data.
    typedef struct packed {
        logic      valid;
        bank_idx_t bank_idx;
        logic      miss;
        logic      we;
    } rsp_trk_t;

    // Read data returned for misses and writes, replicated to the data width.
    localparam logic MISS_RDATA = 1'b0;

endpackage

// File: rtl/core_mem_xbar_rr_arb.sv
// Round-robin arbiter for one SRAM bank: one-hot grant, pointer advances past the winner.
module core_mem_xbar_rr_arb
    import core_mem_xbar_pkg::*;
#(
    parameter int unsigned NB_REQ = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NB_REQ-1:0] i_req,
    output logic [NB_REQ-1:0] o_gnt
);

    master_idx_t r_ptr;
    master_idx_t w_gnt_idx;
    logic        w_any;

    // Search from the pointer upward first, then wrap around to the lower indices.
    always_comb begin
        o_gnt     = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (!w_any && i_req[k] && (k >= int'(r_ptr))) begin
                w_any     = 1'b1;
                w_gnt_idx = master_idx_t'(k);
                o_gnt[k]  = 1'b1;
            end
        end
        for (int k = 0; k < NB_REQ; k++) begin
            if (!w_any && i_req[k] && (k < int'(r_ptr))) begin
                w_any     = 1'b1;
                w_gnt_idx = master_idx_t'(k);
                o_gnt[k]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_gnt_idx == master_idx_t'(NB_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/core_mem_xbar.sv
// N-master x M-bank crossbar: address decode, per-bank round-robin, one-cycle response routing.
// Optional macro CORE_MEM_XBAR_ERR_EN adds m_err_o, flagging decode misses alongside m_rvalid_o.
module core_mem_xbar
    import core_mem_xbar_pkg::*;
#(
    parameter int unsigned NB_MASTER      = 2,
    parameter int unsigned NB_BANK        = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BANK_BYTES     = 32768,
    parameter int unsigned MEM_ADDR_WIDTH = $clog2(BANK_BYTES / (DATA_WIDTH / 8))
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NB_MASTER-1:0]                 m_req_i,
    output logic [NB_MASTER-1:0]                 m_gnt_o,
    output logic [NB_MASTER-1:0]                 m_rvalid_o,
`ifdef CORE_MEM_XBAR_ERR_EN
    output logic [NB_MASTER-1:0]                 m_err_o,
`endif
    input  logic [NB_MASTER-1:0]                 m_we_i,
    input  logic [NB_MASTER*DATA_WIDTH/8-1:0]    m_be_i,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]      m_wdata_i,
    output logic [NB_MASTER*DATA_WIDTH-1:0]      m_rdata_o,
    input  logic [NB_BANK*ADDR_WIDTH-1:0]        start_addr_i,
    input  logic [NB_BANK*ADDR_WIDTH-1:0]        end_addr_i,
    output logic [NB_BANK-1:0]                   mem_req_o,
    output logic [NB_BANK-1:0]                   mem_we_o,
    output logic [NB_BANK*DATA_WIDTH/8-1:0]      mem_be_o,
    output logic [NB_BANK*MEM_ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [NB_BANK*DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic [NB_BANK*DATA_WIDTH-1:0]        mem_rdata_i
);

    localparam int unsigned BE_W       = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = (BE_W > 1) ? $clog2(BE_W) : 0;

    logic [NB_MASTER-1:0]  w_req;
    logic [NB_MASTER-1:0]  w_miss;
    logic [NB_MASTER-1:0]  w_gnt;
    bank_idx_t             w_bidx [NB_MASTER];
    logic [NB_MASTER-1:0]  w_breq [NB_BANK];
    logic [NB_MASTER-1:0]  w_bgnt [NB_BANK];
    logic [ADDR_WIDTH-1:0] w_off  [NB_BANK];
    logic                  w_unused_off;
    rsp_trk_t              r_trk  [NB_MASTER];

    // Requests are masked during reset so nothing is granted or driven to the banks.
    assign w_req = m_req_i & {NB_MASTER{rst_ni}};

    // Descending scan so the lowest-index bank wins on overlapping ranges.
    always_comb begin
        for (int m = 0; m < NB_MASTER; m++) begin
            w_miss[m] = 1'b1;
            w_bidx[m] = '0;
            for (int b = NB_BANK - 1; b >= 0; b--) begin
                if ((m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= start_addr_i[b*ADDR_WIDTH +: ADDR_WIDTH]) &&
                    (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= end_addr_i[b*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    w_miss[m] = 1'b0;
                    w_bidx[m] = bank_idx_t'(b);
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB_BANK; b++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                w_breq[b][m] = w_req[m] & ~w_miss[m] & (w_bidx[m] == bank_idx_t'(b));
            end
        end
    end

    for (genvar gi = 0; gi < NB_BANK; gi++) begin : g_bank
        core_mem_xbar_rr_arb #(
            .NB_REQ (NB_MASTER)
        ) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_req  (w_breq[gi]),
            .o_gnt  (w_bgnt[gi])
        );
    end

    // Misses need no bank slot, so they are granted unconditionally.
    always_comb begin
        for (int m = 0; m < NB_MASTER; m++) begin
            w_gnt[m] = w_req[m] & w_miss[m];
            for (int b = 0; b < NB_BANK; b++) begin
                w_gnt[m] = w_gnt[m] | w_bgnt[b][m];
            end
        end
    end

    assign m_gnt_o = w_gnt;

    always_comb begin
        mem_req_o   = '0;
        mem_we_o    = '0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        for (int b = 0; b < NB_BANK; b++) begin
            w_off[b] = '0;
            for (int m = 0; m < NB_MASTER; m++) begin
                if (w_bgnt[b][m]) begin
                    mem_req_o[b]                        = 1'b1;
                    mem_we_o[b]                         = m_we_i[m];
                    mem_be_o[b*BE_W +: BE_W]            = m_be_i[m*BE_W +: BE_W];
                    mem_wdata_o[b*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
                    w_off[b] = m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] - start_addr_i[b*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
            mem_addr_o[b*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] = w_off[b][BYTE_SHIFT +: MEM_ADDR_WIDTH];
        end
    end

    // Byte-lane and above-bank offset bits are intentionally dropped from the word address.
    always_comb begin
        w_unused_off = 1'b0;
        for (int b = 0; b < NB_BANK; b++) begin
            w_unused_off = w_unused_off ^ (^w_off[b]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                r_trk[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NB_MASTER; m++) begin
                r_trk[m].valid <= w_gnt[m];
                if (w_gnt[m]) begin
                    r_trk[m].bank_idx <= w_bidx[m];
                    r_trk[m].miss     <= w_miss[m];
                    r_trk[m].we       <= m_we_i[m];
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NB_MASTER; m++) begin
            m_rvalid_o[m] = r_trk[m].valid;
`ifdef CORE_MEM_XBAR_ERR_EN
            m_err_o[m]    = r_trk[m].valid & r_trk[m].miss;
`endif
            m_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{MISS_RDATA}};
            if (r_trk[m].valid && !r_trk[m].miss && !r_trk[m].we) begin
                for (int b = 0; b < NB_BANK; b++) begin
                    if (r_trk[m].bank_idx == bank_idx_t'(b)) begin
                        m_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_core_mem_xbar.sv
// Directed self-checking bench for core_mem_xbar (2 masters, 2 banks, behavioural SRAM per bank).
module tb_core_mem_xbar;

    localparam int NM  = 2;
    localparam int NB  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BEW = 4;
    localparam int MAW = 13;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NM-1:0]      m_req, m_we, m_gnt, m_rvalid;
    logic [NM*BEW-1:0]  m_be;
    logic [NM*AW-1:0]   m_addr;
    logic [NM*DW-1:0]   m_wdata, m_rdata;
    logic [NB*AW-1:0]   start_addr, end_addr;
    logic [NB-1:0]      mem_req, mem_we;
    logic [NB*BEW-1:0]  mem_be;
    logic [NB*MAW-1:0]  mem_addr;
    logic [NB*DW-1:0]   mem_wdata;
    logic [NB*DW-1:0]   mem_rdata = '0;
`ifdef CORE_MEM_XBAR_ERR_EN
    logic [NM-1:0]      m_err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] sram [NB][1<<MAW] = '{default: '0};

    always #5 clk = ~clk;

    core_mem_xbar dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .m_req_i      (m_req),
        .m_gnt_o      (m_gnt),
        .m_rvalid_o   (m_rvalid),
`ifdef CORE_MEM_XBAR_ERR_EN
        .m_err_o      (m_err),
`endif
        .m_we_i       (m_we),
        .m_be_i       (m_be),
        .m_addr_i     (m_addr),
        .m_wdata_i    (m_wdata),
        .m_rdata_o    (m_rdata),
        .start_addr_i (start_addr),
        .end_addr_i   (end_addr),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Single-port SRAM: byte-masked write or registered read, one cycle latency.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_req[b]) begin
                if (mem_we[b]) begin
                    for (int j = 0; j < BEW; j++)
                        if (mem_be[b*BEW+j])
                            sram[b][mem_addr[b*MAW +: MAW]][8*j +: 8] <= mem_wdata[b*DW + 8*j +: 8];
                end else begin
                    mem_rdata[b*DW +: DW] <= sram[b][mem_addr[b*MAW +: MAW]];
                end
            end
        end
    end

    task automatic idle_all();
        m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic drive(input int m, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        m_req[m] = 1'b1;
        m_we[m]  = we;
        m_be[m*BEW +: BEW]  = be;
        m_addr[m*AW +: AW]  = addr;
        m_wdata[m*DW +: DW] = wd;
        $display("[%0t] txn m%0d %s addr=%h be=%b wdata=%h", $time, m, we ? "WR" : "RD", addr, be, wd);
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        #1;
        n_cmp++; if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b expected 00", m_gnt); end
        n_cmp++; if (mem_req !== 2'b00) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 00", mem_req); end
        n_cmp++; if (mem_we !== 2'b00) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 00", mem_we); end
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 00", m_rvalid); end
        n_cmp++; if (m_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", m_rdata); end
`ifdef CORE_MEM_XBAR_ERR_EN
        n_cmp++; if (m_err !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b expected 00", m_err); end
`endif
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if ({m_gnt, m_rvalid, mem_req} !== 6'b0) begin n_fail++; $display("FAIL idle_out: got %b expected 000000", {m_gnt, m_rvalid, mem_req}); end
    endtask

    task automatic test_single_read();
        drive(0, 1'b1, 4'hF, 32'h0000_0010, 32'hA5A5_0010);
        #1;
        n_cmp++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL pre_wr_gnt: got %b expected 01", m_gnt); end
        @(negedge clk);
        idle_all();
        drive(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        #1;
        n_cmp++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt: got %b expected 01", m_gnt); end
        n_cmp++; if (mem_req !== 2'b01) begin n_fail++; $display("FAIL rd_mem_req: got %b expected 01", mem_req); end
        n_cmp++; if (mem_addr[12:0] !== 13'd4) begin n_fail++; $display("FAIL rd_mem_addr: got %0d expected 4", mem_addr[12:0]); end
        n_cmp++; if (mem_we !== 2'b00) begin n_fail++; $display("FAIL rd_mem_we: got %b expected 00", mem_we); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid: got %b expected 01", m_rvalid); end
        n_cmp++; if (m_rdata[31:0] !== 32'hA5A5_0010) begin n_fail++; $display("FAIL rd_rdata: got %h expected a5a50010", m_rdata[31:0]); end
        idle_all();
    endtask

    task automatic test_parallel();
        drive(0, 1'b1, 4'hF, 32'h0000_0000, 32'h0BAD_CAFE);
        drive(1, 1'b1, 4'hF, 32'h2000_0000, 32'h2222_3333);
        #1;
        n_cmp++; if (m_gnt !== 2'b11) begin n_fail++; $display("FAIL par_wr_gnt: got %b expected 11", m_gnt); end
        @(negedge clk);
        idle_all();
        drive(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
        drive(1, 1'b0, 4'hF, 32'h2000_0000, 32'h0);
        #1;
        n_cmp++; if (m_gnt !== 2'b11) begin n_fail++; $display("FAIL par_gnt: got %b expected 11", m_gnt); end
        n_cmp++; if (mem_req !== 2'b11) begin n_fail++; $display("FAIL par_mem_req: got %b expected 11", mem_req); end
        n_cmp++; if (mem_addr !== 26'd0) begin n_fail++; $display("FAIL par_mem_addr: got %h expected 0", mem_addr); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b11) begin n_fail++; $display("FAIL par_rvalid: got %b expected 11", m_rvalid); end
        n_cmp++; if (m_rdata[31:0] !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL par_rdata0: got %h expected 0badcafe", m_rdata[31:0]); end
        n_cmp++; if (m_rdata[63:32] !== 32'h2222_3333) begin n_fail++; $display("FAIL par_rdata1: got %h expected 22223333", m_rdata[63:32]); end
        idle_all();
    endtask

    task automatic test_rr();
        logic [1:0]  exp_g [4];
        logic [12:0] exp_a;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        drive(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        drive(1, 1'b0, 4'hF, 32'h0000_0024, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_a = (exp_g[i] == 2'b01) ? 13'd8 : 13'd9;
            #1;
            n_cmp++; if (m_gnt !== exp_g[i]) begin n_fail++; $display("FAIL rr_gnt%0d: got %b expected %b", i, m_gnt, exp_g[i]); end
            n_cmp++; if (mem_addr[12:0] !== exp_a) begin n_fail++; $display("FAIL rr_addr%0d: got %0d expected %0d", i, mem_addr[12:0], exp_a); end
            @(negedge clk);
            n_cmp++; if (m_rvalid !== exp_g[i]) begin n_fail++; $display("FAIL rr_rvalid%0d: got %b expected %b", i, m_rvalid, exp_g[i]); end
        end
        idle_all();
        drive(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        #1;
        n_cmp++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rr_solo_gnt: got %b expected 01", m_gnt); end
        @(negedge clk);
        idle_all();
        #1;
        n_cmp++; if ({m_gnt, mem_req} !== 4'b0000) begin n_fail++; $display("FAIL rr_idle: got %b expected 0000", {m_gnt, mem_req}); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rr_idle_rvalid: got %b expected 00", m_rvalid); end
        drive(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        drive(1, 1'b0, 4'hF, 32'h0000_0024, 32'h0);
        #1;
        n_cmp++; if (m_gnt !== 2'b10) begin n_fail++; $display("FAIL rr_hold_gnt: got %b expected 10", m_gnt); end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_write_readback();
        drive(1, 1'b1, 4'b0011, 32'h2000_0008, 32'hCAFE_F00D);
        #1;
        n_cmp++; if (m_gnt !== 2'b10) begin n_fail++; $display("FAIL wr_gnt: got %b expected 10", m_gnt); end
        n_cmp++; if (mem_req !== 2'b10) begin n_fail++; $display("FAIL wr_mem_req: got %b expected 10", mem_req); end
        n_cmp++; if (mem_we !== 2'b10) begin n_fail++; $display("FAIL wr_mem_we: got %b expected 10", mem_we); end
        n_cmp++; if (mem_be[7:4] !== 4'b0011) begin n_fail++; $display("FAIL wr_mem_be: got %b expected 0011", mem_be[7:4]); end
        n_cmp++; if (mem_addr[25:13] !== 13'd2) begin n_fail++; $display("FAIL wr_mem_addr: got %0d expected 2", mem_addr[25:13]); end
        n_cmp++; if (mem_wdata[63:32] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wr_mem_wdata: got %h expected cafef00d", mem_wdata[63:32]); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b10) begin n_fail++; $display("FAIL wr_rvalid: got %b expected 10", m_rvalid); end
        n_cmp++; if (m_rdata[63:32] !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h expected 0", m_rdata[63:32]); end
        idle_all();
        drive(1, 1'b0, 4'hF, 32'h2000_0008, 32'h0);
        #1;
        n_cmp++; if ({m_gnt, mem_we} !== 4'b1000) begin n_fail++; $display("FAIL rb_gnt_we: got %b expected 1000", {m_gnt, mem_we}); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b10) begin n_fail++; $display("FAIL rb_rvalid: got %b expected 10", m_rvalid); end
        n_cmp++; if (m_rdata[63:32] !== 32'h0000_F00D) begin n_fail++; $display("FAIL rb_rdata: got %h expected 0000f00d", m_rdata[63:32]); end
        idle_all();
    endtask

    task automatic test_miss();
        drive(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        @(negedge clk);
        n_cmp++; if (m_rdata[31:0] !== 32'hA5A5_0010) begin n_fail++; $display("FAIL ms_pre_rdata: got %h expected a5a50010", m_rdata[31:0]); end
        idle_all();
        drive(0, 1'b0, 4'hF, 32'h4000_0000, 32'h0);
        #1;
        n_cmp++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL ms_gnt: got %b expected 01", m_gnt); end
        n_cmp++; if (mem_req !== 2'b00) begin n_fail++; $display("FAIL ms_mem_req: got %b expected 00", mem_req); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL ms_rvalid: got %b expected 01", m_rvalid); end
        n_cmp++; if (m_rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL ms_rdata: got %h expected 0", m_rdata[31:0]); end
`ifdef CORE_MEM_XBAR_ERR_EN
        n_cmp++; if (m_err !== 2'b01) begin n_fail++; $display("FAIL ms_err: got %b expected 01", m_err); end
`endif
        idle_all();
        drive(0, 1'b1, 4'hF, 32'h4000_0004, 32'hDEAD_BEEF);
        #1;
        n_cmp++; if ({m_gnt, mem_req, mem_we} !== 6'b010000) begin n_fail++; $display("FAIL ms_wr: got %b expected 010000", {m_gnt, mem_req, mem_we}); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL ms_wr_rvalid: got %b expected 01", m_rvalid); end
        idle_all();
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL ms_after_rvalid: got %b expected 00", m_rvalid); end
`ifdef CORE_MEM_XBAR_ERR_EN
        n_cmp++; if (m_err !== 2'b00) begin n_fail++; $display("FAIL ms_after_err: got %b expected 00", m_err); end
`endif
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        #1;
        n_cmp++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rm_gnt_a: got %b expected 01", m_gnt); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL rm_rvalid_a: got %b expected 01", m_rvalid); end
        #1;
        n_cmp++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rm_gnt_b: got %b expected 01", m_gnt); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({m_rvalid, m_gnt} !== 4'b0000) begin n_fail++; $display("FAIL rm_in_rst: got %b expected 0000", {m_rvalid, m_gnt}); end
        idle_all();
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_rvalid_rst: got %b expected 00", m_rvalid); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_rvalid_rel: got %b expected 00", m_rvalid); end
        drive(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        drive(1, 1'b0, 4'hF, 32'h0000_0024, 32'h0);
        #1;
        n_cmp++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rm_rr_restart: got %b expected 01", m_gnt); end
        @(negedge clk);
        n_cmp++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL rm_rr_rvalid: got %b expected 01", m_rvalid); end
        idle_all();
        @(negedge clk);
    endtask

    initial begin
        start_addr = {32'h2000_0000, 32'h0000_0000};
        end_addr   = {32'h2000_FFFF, 32'h0000_FFFF};
        idle_all();
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_parallel();
        test_rr();
        test_write_readback();
        test_miss();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
